// File: rtl/mem_array_reader_if.sv
// Bus bundle for mem_array_reader: the memory read port plus the element stream handshake.
interface mem_array_reader_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic [DATA_W-1:0] out_data;
  logic [15:0]       out_index;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (
    output mem_rd_addr,
    input  mem_rd_data,
    output out_data,
    output out_index,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  mem_rd_addr,
    output mem_rd_data,
    input  out_data,
    input  out_index,
    input  out_valid,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/mem_array_reader.sv
// Reads an array length from a header word, streams each element out over valid/ready and
// flags whether the accepted sequence is non-decreasing (unsigned).
module mem_array_reader #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned N_ADDR    = 1,
  parameter int unsigned BASE_ADDR = 2,
  parameter int unsigned MAX_N     = 65534
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  mem_array_reader_if.master bus,
  output logic [DATA_W-1:0] n_value,
  output logic              busy,
  output logic              done,
  output logic              sorted_ok,
  output logic              err_len
);

  typedef enum logic [2:0] {StIdle, StRdN, StRdEl, StHold, StFin} state_e;

  state_e            state_q, state_d;
  logic [15:0]       idx_q;
  logic [DATA_W-1:0] prev_q;
  logic [DATA_W-1:0] out_data_q;
  logic [15:0]       out_index_q;
  logic              out_valid_q;
  logic              out_last_q;
  logic [DATA_W-1:0] n_value_q;
  logic              busy_q;
  logic              done_q;
  logic              sorted_ok_q;
  logic              err_len_q;

  logic              n_zero;
  logic              n_too_big;
  logic              is_last;
  logic              accept;

  assign n_zero    = (bus.mem_rd_data == '0);
  assign n_too_big = (bus.mem_rd_data > DATA_W'(MAX_N));
  assign is_last   = (DATA_W'(idx_q) == n_value_q - DATA_W'(1));
  assign accept    = out_valid_q & bus.out_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start) state_d = StRdN;
      StRdN: begin
        if (n_zero || n_too_big) begin
          state_d = StFin;
        end else begin
          state_d = StRdEl;
        end
      end
      StRdEl: state_d = StHold;
      StHold: begin
        if (accept) begin
          state_d = out_last_q ? StFin : StRdEl;
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Memory address decode; the element address is widened before the add so it never wraps.
  always_comb begin
    bus.mem_rd_addr = '0;
    unique case (state_q)
      StRdN:   bus.mem_rd_addr = ADDR_W'(N_ADDR);
      StRdEl:  bus.mem_rd_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(idx_q);
      default: bus.mem_rd_addr = '0;
    endcase
  end

  // Datapath and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= '0;
      prev_q      <= '0;
      out_data_q  <= '0;
      out_index_q <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      n_value_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sorted_ok_q <= 1'b1;
      err_len_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            done_q      <= 1'b0;
            err_len_q   <= 1'b0;
            out_index_q <= '0;
            n_value_q   <= '0;
            sorted_ok_q <= 1'b1;
            busy_q      <= 1'b1;
            idx_q       <= '0;
          end
        end
        StRdN: begin
          n_value_q <= bus.mem_rd_data;
          idx_q     <= '0;
          if (n_zero) begin
            sorted_ok_q <= 1'b1;
          end else if (n_too_big) begin
            err_len_q <= 1'b1;
          end
        end
        StRdEl: begin
          out_data_q  <= bus.mem_rd_data;
          out_index_q <= idx_q;
          out_last_q  <= is_last;
          out_valid_q <= 1'b1;
          if ((idx_q != '0) && (bus.mem_rd_data < prev_q)) begin
            sorted_ok_q <= 1'b0;
          end
        end
        StHold: begin
          if (accept) begin
            out_valid_q <= 1'b0;
            prev_q      <= out_data_q;
            if (!out_last_q) begin
              idx_q <= idx_q + 16'd1;
            end
          end
        end
        StFin: begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_index = out_index_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign n_value       = n_value_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign sorted_ok     = sorted_ok_q;
  assign err_len       = err_len_q;

endmodule

// File: tb/tb_mem_array_reader.sv
// Self-checking bench for mem_array_reader: a table of readouts, random arrays against a
// prefix-sortedness model, and hand sequences for reset-in-HOLD and start-while-busy.
module tb_mem_array_reader;

  localparam int unsigned N_ADDR = 1;
  localparam int unsigned BASE   = 2;
  localparam int unsigned MAX_N  = 65534;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] n_value;
  logic        busy;
  logic        done;
  logic        sorted_ok;
  logic        err_len;
  logic [31:0] mem [64];

  int n_pass  = 0;
  int n_total = 0;

  mem_array_reader_if #(.DATA_W(32), .ADDR_W(32)) bus ();

  mem_array_reader #(
    .DATA_W   (32),
    .ADDR_W   (32),
    .N_ADDR   (N_ADDR),
    .BASE_ADDR(BASE),
    .MAX_N    (MAX_N)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bus      (bus.master),
    .n_value  (n_value),
    .busy     (busy),
    .done     (done),
    .sorted_ok(sorted_ok),
    .err_len  (err_len)
  );

  assign bus.mem_rd_data = mem[bus.mem_rd_addr[5:0]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] n;
    logic [31:0] e0, e1, e2, e3;
    bit          rnd_ready;
    bit          poke;
    bit          exp_sorted;
    bit          exp_err;
    int          exp_cycles;
  } vec_t;

  vec_t vecs[$];

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endfunction

  task automatic add_vec(input logic [31:0] n, input logic [31:0] e0, input logic [31:0] e1,
                         input logic [31:0] e2, input logic [31:0] e3, input bit rnd,
                         input bit poke, input bit s, input bit e, input int cyc);
    vec_t v;
    v.n = n; v.e0 = e0; v.e1 = e1; v.e2 = e2; v.e3 = e3;
    v.rnd_ready = rnd; v.poke = poke; v.exp_sorted = s; v.exp_err = e; v.exp_cycles = cyc;
    vecs.push_back(v);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_addr"}, bus.mem_rd_addr, 0);
    check({tag, "_data"}, bus.out_data, 0);
    check({tag, "_index"}, bus.out_index, 0);
    check({tag, "_valid"}, bus.out_valid, 0);
    check({tag, "_last"}, bus.out_last, 0);
    check({tag, "_n_value"}, n_value, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_sorted_ok"}, sorted_ok, 1);
    check({tag, "_err_len"}, err_len, 0);
  endtask

  // One complete readout of whatever mem holds; expectations come from mem alone.
  task automatic run_readout(input bit rand_ready, input bit poke_start, output int cycles,
                             output bit model_sorted, output bit model_err);
    logic [31:0] n;
    int          cnt;
    int          got;
    bit          stall;
    logic [31:0] hold_d;
    logic [15:0] hold_i;
    logic        hold_l;
    n            = mem[N_ADDR];
    model_err    = (n > MAX_N);
    cnt          = model_err ? 0 : int'(n);
    model_sorted = 1'b1;
    got          = 0;
    stall        = 1'b0;
    hold_d = '0; hold_i = '0; hold_l = 1'b0;
    @(negedge clk);
    start     = 1'b1;
    out_ready_set(1'b1);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("done_cleared", done, 0);
    cycles = 0;
    while (cycles < 400) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
      start = 1'b0;
      if (done) break;
      if (poke_start && cycles == 3) start = 1'b1;
      if (stall) begin
        check("stall_data", bus.out_data, hold_d);
        check("stall_index", bus.out_index, hold_i);
        check("stall_last", bus.out_last, hold_l);
        check("stall_valid", bus.out_valid, 1);
      end
      out_ready_set(rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
      stall = 1'b0;
      if (bus.out_valid) begin
        if (bus.out_ready) begin
          if (got < cnt) begin
            if (got > 0 && mem[BASE+got] < mem[BASE+got-1]) model_sorted = 1'b0;
            check("elem_data", bus.out_data, mem[BASE+got]);
            check("elem_index", bus.out_index, got);
            check("elem_last", bus.out_last, (got == cnt - 1));
            check("sorted_at_elem", sorted_ok, model_sorted);
          end else begin
            check("extra_elem", got, cnt);
          end
          got++;
        end else begin
          stall  = 1'b1;
          hold_d = bus.out_data;
          hold_i = bus.out_index;
          hold_l = bus.out_last;
        end
      end
    end
    check("done_set", done, 1);
    check("elem_count", got, cnt);
    check("final_sorted_ok", sorted_ok, model_sorted);
    check("final_err_len", err_len, model_err);
    check("final_n_value", n_value, n);
    check("final_busy", busy, 0);
    check("final_valid", bus.out_valid, 0);
  endtask

  task automatic out_ready_set(input logic r);
    bus.out_ready = r;
  endtask

  initial begin
    int  cyc;
    bit  ms;
    bit  me;
    bit  found;
    vec_t v;
    rst_n = 1'b0;
    start = 1'b0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    #12;
    check_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;

    //      n       e0 e1 e2 e3            rnd poke sorted err cycles
    add_vec(3,      1, 2, 3, 0,            0,  0,   1,     0,  8);
    add_vec(3,      3, 1, 2, 0,            0,  0,   0,     0,  8);
    add_vec(0,      9, 9, 9, 9,            0,  0,   1,     0,  2);
    add_vec(70000,  1, 2, 3, 4,            0,  0,   1,     1,  2);
    add_vec(1,      7, 0, 0, 0,            0,  0,   1,     0,  4);
    add_vec(4,      5, 5, 9, 2,            1,  0,   0,     0,  -1);
    add_vec(4,      0, 1, 1, 32'hFFFFFFFF, 1,  1,   1,     0,  -1);
    add_vec(2,      8, 3, 0, 0,            0,  1,   0,     0,  6);

    foreach (vecs[k]) begin
      v = vecs[k];
      mem[N_ADDR] = v.n;
      mem[BASE] = v.e0; mem[BASE+1] = v.e1; mem[BASE+2] = v.e2; mem[BASE+3] = v.e3;
      run_readout(v.rnd_ready, v.poke, cyc, ms, me);
      check("tbl_sorted_ok", sorted_ok, v.exp_sorted);
      check("tbl_err_len", err_len, v.exp_err);
      if (v.exp_cycles >= 0) check("tbl_done_latency", cyc, v.exp_cycles);
    end

    // 25-entry permutation of 1..25, then the same values in order
    mem[N_ADDR] = 25;
    for (int i = 0; i < 25; i++) mem[BASE+i] = (i * 7) % 25 + 1;
    run_readout(1'b0, 1'b0, cyc, ms, me);
    check("perm_unsorted", sorted_ok, 0);
    for (int i = 0; i < 25; i++) mem[BASE+i] = i + 1;
    run_readout(1'b0, 1'b0, cyc, ms, me);
    check("perm_sorted", sorted_ok, 1);
    check("perm_latency", cyc, 52);

    // Random arrays with random back-pressure
    for (int t = 0; t < 12; t++) begin
      int unsigned n;
      n = $urandom_range(1, 20);
      mem[N_ADDR] = n;
      for (int i = 0; i < int'(n); i++) begin
        mem[BASE+i] = $urandom_range(0, 15);
        if (t % 2 == 0 && i > 0) mem[BASE+i] = mem[BASE+i-1] + mem[BASE+i];
      end
      run_readout(1'b1, 1'b0, cyc, ms, me);
      if (t % 2 == 0) check("rand_sorted_case", sorted_ok, 1);
    end

    // Reset while holding element 5 of 10
    mem[N_ADDR] = 10;
    for (int i = 0; i < 10; i++) mem[BASE+i] = 100 + i;
    @(negedge clk);
    start = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (bus.out_valid && bus.out_index == 16'd5) begin
        found = 1'b1;
        bus.out_ready = 1'b0;
        break;
      end
      @(negedge clk);
    end
    check("hold_idx5_reached", found, 1);
    @(negedge clk);
    check("hold_idx5_stable", bus.out_index, 5);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    run_readout(1'b0, 1'b0, cyc, ms, me);
    check("post_reset_latency", cyc, 22);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_array_reader.md
Name: mem_array_reader

Overview:
- Read-side initiator for the word-addressed data memory.
- On a start pulse it reads the array length from a fixed header word, then walks the array one word at a time.
- Each element is streamed out over a valid/ready handshake, and the block checks that the sequence is non-decreasing (unsigned).
- Used by the bench and the post-sort readout path to drain and verify the sorted result after the CPU halts.

Parameters:
- DATA_W, 32, memory word and element width.
- ADDR_W, 32, memory read address width.
- N_ADDR, 1, address of the word holding the element count n.
- BASE_ADDR, 2, address of element 0.
- MAX_N, 65534, largest legal n (BASE_ADDR+n-1 must stay ≤ 65535).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a readout; ignored while busy=1.
- mem_rd_addr  out  ADDR_W  read address driven to the data memory.
- mem_rd_data  in  DATA_W  combinational read data for mem_rd_addr (same-cycle).
- out_data  out  DATA_W  current element.
- out_index  out  16  index of the current element (0-based).
- out_valid  out  1  out_data/out_index/out_last valid.
- out_ready  in  1  consumer accepts the element when out_valid&out_ready.
- out_last  out  1  current element is index n-1.
- n_value  out  DATA_W  latched element count.
- busy  out  1  readout in progress.
- done  out  1  readout finished; held until next accepted start.
- sorted_ok  out  1  1 if every accepted element ≥ its predecessor (unsigned).
- err_len  out  1  n > MAX_N; readout aborted.

Behaviour:
- Reset (async, rst_n=0): state=IDLE.
  - All outputs 0, except sorted_ok=1.
  - mem_rd_addr=0.
  - Reset mid-readout aborts immediately; no element completes.
- States: IDLE, RD_N, RD_EL, HOLD, FIN.
- IDLE:
  - mem_rd_addr=0.
  - On start=1: clear done, err_len, out_index and n_value; set sorted_ok=1, busy=1; go to RD_N.
- RD_N:
  - mem_rd_addr=N_ADDR; at the edge, n_value<=mem_rd_data.
  - If mem_rd_data==0: go to FIN with sorted_ok=1.
  - Else if mem_rd_data>MAX_N: err_len<=1; go to FIN.
  - Else: go to RD_EL with idx=0.
- RD_EL:
  - mem_rd_addr=BASE_ADDR+idx, computed in ADDR_W bits with no wrap.
  - At the edge: out_data<=mem_rd_data, out_index<=idx, out_last<=(idx==n-1), out_valid<=1; go to HOLD.
  - If idx>0 and mem_rd_data < the previously accepted element: sorted_ok<=0.
- HOLD:
  - out_data, out_index and out_last are stable while out_valid=1 and out_ready=0. The consumer may hold off indefinitely.
  - On out_valid&out_ready: out_valid<=0 and prev<=out_data.
    - If out_last: go to FIN.
    - Else: idx<=idx+1; go to RD_EL.
- FIN: busy<=0, done<=1; go to IDLE. done stays high until the next accepted start.
- Throughput: with out_ready tied high, one element per 2 cycles.
  - First out_valid rises 2 cycles after the start edge.
  - done rises 2n+2 cycles after the start edge (n≥1).
- start is ignored while busy=1, including the cycle of the start edge.
- start is accepted in the same cycle that done is set only if state==IDLE.
- sorted_ok is sticky-low for the remainder of a readout.
- n=1: the single element has out_last=1, and sorted_ok stays 1.
- The memory is read only; the block never writes.

Test Plan:
- mem[1]=3, mem[2..4]={1,2,3}, out_ready=1, pulse start → elements 1,2,3 on out_index 0,1,2; out_last only on index 2; done after 8 cycles; sorted_ok=1.
- mem[1]=3, mem[2..4]={3,1,2} → sorted_ok drops when element 1 is presented and stays 0; done=1; err_len=0.
- mem[1]=25 with the 25-entry permutation stored unsorted → sorted_ok=0. Same memory holding 1..25 → sorted_ok=1, 25 handshakes, out_last on index 24.
- out_ready toggled pseudo-randomly, n=4 → out_data/out_index stable during stalls; no duplicates or drops; order 0..3.
- mem[1]=0 → no out_valid, done=1, sorted_ok=1. mem[1]=70000 → err_len=1, done=1, no out_valid.
- rst_n asserted while in HOLD at index 5 of 10 → all outputs go to reset values asynchronously. A following start re-reads from index 0. A start pulsed while busy has no effect.
